// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads through a prefetch register.
module sync_fifo_prog #(
    parameter int DSIZE       = 8,
    parameter int ASIZE       = 4,
    parameter int ALMOSTFULL  = 1,
    parameter int ALMOSTEMPTY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             walmostfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmostempty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] FULL_LVL = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_LVL   = (ASIZE+1)'(DEPTH - ALMOSTFULL);
    localparam logic [ASIZE:0] AE_LVL   = (ASIZE+1)'(ALMOSTEMPTY);
    localparam logic [ASIZE:0] ZERO     = '0;
    localparam logic [ASIZE:0] ONE      = (ASIZE+1)'(1);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wptr;
    logic [ASIZE:0]   rptr;
    logic [ASIZE:0]   count_next;
    logic             wr_ok;
    logic             rd_ok;

    assign wfull        = (count == FULL_LVL);
    assign walmostfull  = (count >= AF_LVL);
    assign ralmostempty = (count <= AE_LVL);

    assign wr_ok = winc & (~wfull | rd_ok);

    always_comb begin
        count_next = count;
        if (wr_ok & ~rd_ok) begin
            count_next = count + ONE;
        end else if (rd_ok & ~wr_ok) begin
            count_next = count - ONE;
        end
    end

    // Storage is never reset; stale words are unreachable behind the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= ZERO;
            count <= ZERO;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + ONE;
            end
            count <= count_next;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // The output register holds the head word; count covers it as well.
    logic ovalid;
    logic mem_ne;
    logic load;

    assign rempty = ~ovalid;
    assign rd_ok  = rinc & ovalid;
    assign mem_ne = (wptr != rptr);
    assign load   = mem_ne & (~ovalid | rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr   <= ZERO;
            rdata  <= '0;
            ovalid <= 1'b0;
        end else if (load) begin
            rptr   <= rptr + ONE;
            rdata  <= mem[rptr[ASIZE-1:0]];
            ovalid <= 1'b1;
        end else if (rd_ok) begin
            ovalid <= 1'b0;
        end
    end
`else
    assign rempty = (count == ZERO);
    assign rd_ok  = rinc & ~rempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= ZERO;
            rdata <= '0;
        end else if (rd_ok) begin
            rptr  <= rptr + ONE;
            rdata <= mem[rptr[ASIZE-1:0]];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (winc & wfull & ~rd_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rinc & rempty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: queue-based reference model compared every cycle,
// plus directed literal expectations at the interesting points.
module tb_sync_fifo_prog;

    localparam int DSIZE = 8;
    localparam int ASIZE = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic             winc = 1'b0;
    logic             rinc = 1'b0;
    logic             err_clr = 1'b0;
    logic             wfull, walmostfull, rempty, ralmostempty;
    logic             overflow, underflow;
    logic [DSIZE-1:0] rdata;
    logic [ASIZE:0]   count;

    sync_fifo_prog #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .ALMOSTFULL(1), .ALMOSTEMPTY(1)
    ) dut (
        .clk(clk), .rst(rst), .wdata(wdata), .winc(winc),
        .wfull(wfull), .walmostfull(walmostfull), .rinc(rinc),
        .rdata(rdata), .rempty(rempty), .ralmostempty(ralmostempty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic [7:0] m_rdata = '0;
    bit         m_ovf = 0;
    bit         m_unf = 0;
    bit         m_vis = 0;
    bit         chk_en = 0;
    int         errors = 0;
    int         checks = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", int'(count), q.size());
            chk("wfull", int'(wfull), int'(q.size() == DEPTH));
            chk("walmostfull", int'(walmostfull), int'(q.size() >= DEPTH - 1));
            chk("ralmostempty", int'(ralmostempty), int'(q.size() <= 1));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
            chk("rempty", int'(rempty), int'(!m_vis));
            if (m_vis) chk("rdata_head", int'(rdata), int'(q[0]));
`else
            chk("rempty", int'(rempty), int'(q.size() == 0));
            chk("rdata", int'(rdata), int'(m_rdata));
`endif
        end
    end

    task automatic step(input bit w, input logic [7:0] d, input bit r,
                        input bit c, input bit rs);
        int sz;
        bit can_rd, rd_ok, wr_ok, full;
        winc = w; wdata = d; rinc = r; err_clr = c; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_rdata = '0; m_ovf = 0; m_unf = 0; m_vis = 0;
        end else begin
            sz = q.size();
`ifdef SYNC_FIFO_FWFT_EN
            can_rd = m_vis;
`else
            can_rd = (sz > 0);
`endif
            rd_ok = r && can_rd;
            full  = (sz == DEPTH);
            wr_ok = w && (!full || rd_ok);
            if (w && full && !rd_ok) m_ovf = 1;
            else if (c) m_ovf = 0;
            if (r && !can_rd) m_unf = 1;
            else if (c) m_unf = 0;
            if (rd_ok) m_rdata = q.pop_front();
            if (wr_ok) q.push_back(d);
            m_vis = (q.size() > 0) && !(wr_ok && q.size() == 1);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        step(0, 8'h00, 0, 0, 1);
        chk_en = 1;
        step(0, 8'h00, 0, 0, 1);
        chk("rst_count", int'(count), 0);
        chk("rst_rempty", int'(rempty), 1);

        for (int i = 0; i < 4; i++) begin
            step(1, 8'hA1 + 8'(i), 0, 0, 0);
            if (i == 2) chk("t1_afull_at3", int'(walmostfull), 1);
            if (i == 2) chk("t1_notfull_at3", int'(wfull), 0);
            if (i == 3) chk("t1_full_at4", int'(wfull), 1);
        end
        step(1, 8'hA5, 0, 0, 0);
        chk("t1_ovf", int'(overflow), 1);
        chk("t1_count", int'(count), 4);

        for (int i = 0; i < 4; i++) begin
            step(0, 8'h00, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
            chk("t2_rdata", int'(rdata), 'hA1 + i);
`endif
        end
        step(0, 8'h00, 1, 0, 0);
        chk("t2_unf", int'(underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t2_hold", int'(rdata), 'hA4);
`endif
        step(0, 8'h00, 0, 1, 0);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_unf", int'(underflow), 0);

        for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), 0, 0, 0);
        step(1, 8'hB0, 1, 0, 0);
        chk("t3_count", int'(count), 4);
        chk("t3_noovf", int'(overflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t3_rdata", int'(rdata), 'hA1);
`endif
        for (int i = 0; i < 12; i++) step(1, 8'h10 + 8'(i), 1, 0, 0);

        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
        step(1, 8'hC1, 1, 0, 0);
        chk("t4_count", int'(count), 1);
        chk("t4_unf", int'(underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t4_rdata", int'(rdata), 'h1B);
`endif
        step(0, 8'h00, 0, 1, 0);
        chk("t4_clr", int'(underflow), 0);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 1, 0);
        chk("t4_set_wins", int'(underflow), 1);

        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 8'h70 + 8'(i), 0, 0, 0);
        chk("t5_count3", int'(count), 3);
        step(0, 8'h00, 0, 0, 1);
        chk("t5_count", int'(count), 0);
        chk("t5_rempty", int'(rempty), 1);
        chk("t5_aempty", int'(ralmostempty), 1);
        chk("t5_wfull", int'(wfull), 0);
        chk("t5_afull", int'(walmostfull), 0);
        step(1, 8'hD1, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t5_rdata", int'(rdata), 'hD1);
`endif

`ifdef SYNC_FIFO_FWFT_EN
        step(0, 8'h00, 0, 0, 1);
        step(1, 8'h5A, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("t6_rempty", int'(rempty), 0);
        chk("t6_rdata", int'(rdata), 'h5A);
        step(0, 8'h00, 1, 0, 0);
        chk("t6_pop", int'(rempty), 1);
`endif

        step(0, 8'h00, 0, 0, 0);
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
